// File: rtl/hazard_pkg.sv
// Shared definitions for the decode-stage hazard scoreboard and the decode unit that drives
// issue_lat.
package hazard_pkg;

    localparam int unsigned REG_W          = 3;
    localparam int unsigned CNT_W          = 2;
    localparam int unsigned LAT_ALU        = 0;
    localparam int unsigned LAT_LOAD       = 1;
    localparam int unsigned WB_LAT_DEFAULT = 2;

    function automatic int unsigned clamp_lat(input int unsigned lat, input int unsigned max_lat);
        return (lat > max_lat) ? max_lat : lat;
    endfunction

endpackage

// File: rtl/pend_counter.sv
// One countdown cell: cycles until a register's pending result becomes readable.
module pend_counter #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             busy
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A load beats the decrement so a newer producer (WAW) replaces the older countdown.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage RAW hazard detector: per-register countdown scoreboard, issue stall and a
// saturating stall-cycle counter.
module hazard_scoreboard #(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned REG_W    = 3,
    parameter int unsigned WB_LAT   = 2,
    parameter int unsigned MAX_LAT  = 3,
    parameter int unsigned CNT_W    = 2,
    parameter bit          FWD_EN   = 1'b0,
    parameter int unsigned PERF_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    input  logic [REG_W-1:0]    rs1_sel,
    input  logic                rs1_used,
    input  logic [REG_W-1:0]    rs2_sel,
    input  logic                rs2_used,
    input  logic [REG_W-1:0]    rd_sel,
    input  logic                rd_write,
    input  logic [CNT_W-1:0]    issue_lat,
    input  logic                flush,
    output logic                stall,
    output logic [NUM_REGS-1:0] pend_mask,
    output logic [PERF_W-1:0]   stall_count
);

    import hazard_pkg::*;

    logic [NUM_REGS-1:0] busy;
    logic [CNT_W-1:0]    load_val;
    logic                issue_fire;
    logic                rs1_hazard;
    logic                rs2_hazard;
    logic [PERF_W-1:0]   stall_count_q;

    assign rs1_hazard = rs1_used & busy[rs1_sel];
    assign rs2_hazard = rs2_used & busy[rs2_sel];
    assign stall      = issue_valid & ~flush & (rs1_hazard | rs2_hazard);
    assign issue_fire = issue_valid & ~stall & ~flush & rd_write;

    always_comb begin
        load_val = CNT_W'(WB_LAT);
        if (FWD_EN) begin
            load_val = CNT_W'(clamp_lat(32'(issue_lat), MAX_LAT));
        end
    end

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
        pend_counter #(
            .CNT_W (CNT_W)
        ) u_pend_counter (
            .clk      (clk),
            .rst      (rst),
            .load     (issue_fire && (rd_sel == REG_W'(r))),
            .load_val (load_val),
            .busy     (busy[r])
        );
    end

    assign pend_mask = busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count_q <= '0;
        end else if (stall && (stall_count_q != '1)) begin
            stall_count_q <= stall_count_q + PERF_W'(1);
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: a fixed-latency instance and a forwarding instance with a narrow
// perf counter and MAX_LAT=2, driven from one shared stimulus table plus corner-case sequences.
module tb_hazard_scoreboard;

    import hazard_pkg::*;

    typedef struct {
        logic       v;
        logic [2:0] rs1;
        logic       u1;
        logic [2:0] rs2;
        logic       u2;
        logic [2:0] rd;
        logic       w;
        logic [1:0] lat;
        logic       fl;
        int         dut;
        logic       es;
        logic [7:0] ep;
        int unsigned ec;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       issue_valid;
    logic [2:0] rs1_sel;
    logic       rs1_used;
    logic [2:0] rs2_sel;
    logic       rs2_used;
    logic [2:0] rd_sel;
    logic       rd_write;
    logic [1:0] issue_lat;
    logic       flush;

    logic        stall0;
    logic [7:0]  pend0;
    logic [15:0] count0;
    logic        stall1;
    logic [7:0]  pend1;
    logic [3:0]  count1;

    int n_vec;
    int n_err;

    vec_t vec[24];
    vec_t exp_q[$];

    hazard_scoreboard #(
        .NUM_REGS (8),
        .REG_W    (3),
        .WB_LAT   (WB_LAT_DEFAULT),
        .MAX_LAT  (3),
        .CNT_W    (2),
        .FWD_EN   (1'b0),
        .PERF_W   (16)
    ) dut0 (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .rs1_sel     (rs1_sel),
        .rs1_used    (rs1_used),
        .rs2_sel     (rs2_sel),
        .rs2_used    (rs2_used),
        .rd_sel      (rd_sel),
        .rd_write    (rd_write),
        .issue_lat   (issue_lat),
        .flush       (flush),
        .stall       (stall0),
        .pend_mask   (pend0),
        .stall_count (count0)
    );

    hazard_scoreboard #(
        .NUM_REGS (8),
        .REG_W    (3),
        .WB_LAT   (WB_LAT_DEFAULT),
        .MAX_LAT  (2),
        .CNT_W    (2),
        .FWD_EN   (1'b1),
        .PERF_W   (4)
    ) dut1 (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .rs1_sel     (rs1_sel),
        .rs1_used    (rs1_used),
        .rs2_sel     (rs2_sel),
        .rs2_used    (rs2_used),
        .rd_sel      (rd_sel),
        .rd_write    (rd_write),
        .issue_lat   (issue_lat),
        .flush       (flush),
        .stall       (stall1),
        .pend_mask   (pend1),
        .stall_count (count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic v, input logic [2:0] rs1, input logic u1,
                                input logic [2:0] rs2, input logic u2, input logic [2:0] rd,
                                input logic w, input int unsigned lat, input logic fl,
                                input int dut, input logic es, input logic [7:0] ep,
                                input int unsigned ec);
        vec_t t;
        t.v = v; t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2; t.rd = rd; t.w = w;
        t.lat = 2'(lat); t.fl = fl; t.dut = dut; t.es = es; t.ep = ep; t.ec = ec;
        return t;
    endfunction

    function automatic vec_t idle(input int dut, input logic [7:0] ep, input int unsigned ec);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, dut, 0, ep, ec);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t t);
        issue_valid = t.v;
        rs1_sel     = t.rs1;
        rs1_used    = t.u1;
        rs2_sel     = t.rs2;
        rs2_used    = t.u2;
        rd_sel      = t.rd;
        rd_write    = t.w;
        issue_lat   = t.lat;
        flush       = t.fl;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(idle(0, 8'h00, 0));
        rst = 1'b1;
        #1;
        chk("rst_pend0", 32'(pend0), 0);
        chk("rst_pend1", 32'(pend1), 0);
        chk("rst_cnt0", 32'(count0), 0);
        chk("rst_cnt1", 32'(count1), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        vec_t e;
        string tag;
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        drive(idle(0, 8'h00, 0));

        // Fixed latency: r3 producer, dependent stalls two cycles, then r4 decays.
        vec[0]  = mk(1, 0, 0, 0, 0, 3, 1, LAT_ALU, 0, 0, 0, 8'h00, 0);
        vec[1]  = mk(1, 3, 1, 0, 0, 4, 1, LAT_ALU, 0, 0, 1, 8'h08, 0);
        vec[2]  = mk(1, 3, 1, 0, 0, 4, 1, LAT_ALU, 0, 0, 1, 8'h08, 1);
        vec[3]  = mk(1, 3, 1, 0, 0, 4, 1, LAT_ALU, 0, 0, 0, 8'h00, 2);
        vec[4]  = idle(0, 8'h10, 2);
        vec[5]  = idle(0, 8'h10, 2);
        vec[6]  = idle(0, 8'h00, 2);
        // Forwarding: ALU producer never stalls, load producer stalls once (same reg on both srcs).
        vec[7]  = mk(1, 0, 0, 0, 0, 2, 1, LAT_ALU, 0, 1, 0, 8'h00, 0);
        vec[8]  = mk(1, 2, 1, 0, 0, 0, 0, LAT_ALU, 0, 1, 0, 8'h00, 0);
        vec[9]  = mk(1, 0, 0, 0, 0, 2, 1, LAT_LOAD, 0, 1, 0, 8'h00, 0);
        vec[10] = mk(1, 2, 1, 2, 1, 0, 0, LAT_ALU, 0, 1, 1, 8'h04, 0);
        vec[11] = mk(1, 2, 1, 2, 1, 0, 0, LAT_ALU, 0, 1, 0, 8'h00, 1);
        // WAW: long producer on r5 overwritten by a short one.
        vec[12] = mk(1, 0, 0, 0, 0, 5, 1, 3, 0, 1, 0, 8'h00, 1);
        vec[13] = mk(1, 0, 0, 0, 0, 5, 1, LAT_LOAD, 0, 1, 0, 8'h20, 1);
        vec[14] = mk(1, 0, 0, 5, 1, 0, 0, LAT_ALU, 0, 1, 1, 8'h20, 1);
        vec[15] = mk(1, 0, 0, 5, 1, 0, 0, LAT_ALU, 0, 1, 0, 8'h00, 2);
        // Flush over a pending RAW; lat 3 clamps to MAX_LAT=2 on this instance.
        vec[16] = mk(1, 0, 0, 0, 0, 1, 1, 3, 0, 1, 0, 8'h00, 2);
        vec[17] = mk(1, 1, 1, 0, 0, 6, 1, 3, 1, 1, 0, 8'h02, 2);
        vec[18] = mk(1, 6, 1, 0, 0, 0, 0, LAT_ALU, 0, 1, 0, 8'h02, 2);
        vec[19] = idle(1, 8'h00, 2);
        vec[20] = idle(1, 8'h00, 2);
        // Self-dependence, then rs2_used=0 masks a pending rs2.
        vec[21] = mk(1, 7, 1, 0, 0, 7, 1, LAT_LOAD, 0, 1, 0, 8'h00, 2);
        vec[22] = mk(1, 0, 1, 7, 0, 0, 0, LAT_ALU, 0, 1, 0, 8'h80, 2);
        vec[23] = idle(1, 8'h00, 2);

        #1;
        chk("init_stall0", 32'(stall0), 0);
        chk("init_stall1", 32'(stall1), 0);
        do_reset();

        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            drive(vec[i]);
            exp_q.push_back(vec[i]);
            #1;
            e = exp_q.pop_front();
            tag = $sformatf("vec%0d", i);
            if (e.dut == 0) begin
                chk({tag, "_stall"}, 32'(stall0), 32'(e.es));
                chk({tag, "_pend"}, 32'(pend0), 32'(e.ep));
                chk({tag, "_count"}, 32'(count0), e.ec);
            end else begin
                chk({tag, "_stall"}, 32'(stall1), 32'(e.es));
                chk({tag, "_pend"}, 32'(pend1), 32'(e.ep));
                chk({tag, "_count"}, 32'(count1), e.ec);
            end
        end

        // Asynchronous reset in the middle of a stall.
        do_reset();
        @(negedge clk);
        drive(mk(1, 0, 0, 0, 0, 1, 1, 2, 0, 0, 0, 0, 0));
        #1;
        chk("mid_issue_stall", 32'(stall0), 0);
        @(negedge clk);
        drive(mk(1, 1, 1, 0, 0, 0, 0, LAT_ALU, 0, 0, 0, 0, 0));
        #1;
        chk("mid_stall_a", 32'(stall0), 1);
        chk("mid_pend_a", 32'(pend0), 32'h02);
        @(negedge clk);
        #1;
        chk("mid_stall_b", 32'(stall0), 1);
        chk("mid_count_b", 32'(count0), 1);
        chk("mid_count1_b", 32'(count1), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_pend0", 32'(pend0), 0);
        chk("mid_rst_stall0", 32'(stall0), 0);
        chk("mid_rst_count0", 32'(count0), 0);
        chk("mid_rst_pend1", 32'(pend1), 0);
        chk("mid_rst_stall1", 32'(stall1), 0);
        chk("mid_rst_count1", 32'(count1), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_stall0", 32'(stall0), 0);
        chk("post_rst_stall1", 32'(stall1), 0);

        // Self-reloading RAW on r3: both instances stall two of every three cycles.
        do_reset();
        @(negedge clk);
        drive(mk(1, 0, 0, 0, 0, 3, 1, 3, 0, 0, 0, 0, 0));
        #1;
        chk("perf_head_stall0", 32'(stall0), 0);
        for (int k = 1; k <= 28; k++) begin
            @(negedge clk);
            drive(mk(1, 3, 1, 0, 0, 3, 1, 3, 0, 0, 0, 0, 0));
            #1;
            chk($sformatf("perf%0d_stall0", k), 32'(stall0), ((k % 3) != 0) ? 1 : 0);
            chk($sformatf("perf%0d_stall1", k), 32'(stall1), ((k % 3) != 0) ? 1 : 0);
        end
        @(negedge clk);
        drive(idle(0, 8'h00, 0));
        #1;
        chk("perf_count0", 32'(count0), 19);
        chk("perf_count1_sat", 32'(count1), 15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
